// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for a common-anode seven-segment bank. A shadow
//   copy of a packed hex value is scanned one digit per refresh slot. Each
//   slot drives one anode, and that digit's nibble is decoded to a 0-F glyph.
//
// Parameters
//   NUM_DIGITS   digits scanned (1..8); nibble i drives digit i, digit 0 rightmost
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//   SEG_ACT_LOW  1: segment on = 0; 0: segment on = 1
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   value       packed hex digits, nibble i = value[4i+3:4i]
//   load        capture value into the shadow register this cycle
//   blank_mask  bit i forces digit i dark (sampled live, not shadowed)
//   seg         segments {g,f,e,d,c,b,a}, registered
//   an          anode enables, active-low, registered, at most one low
//   digit_idx   digit slot in progress
//   slot_tick   high on the last cycle of each slot
//
// Build option
//   SEG7_LZ_SUPPRESS_EN  when defined, leading zeros of the shadow value are
//                        dark (digit 0 always shows). Suppression is ORed with
//                        blank_mask.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int SEG_ACT_LOW = 1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CNT_W = $clog2(REFRESH_DIV)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    slot_tick
);

  localparam logic [6:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;

  logic [CNT_W-1:0]        div_cnt;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    slot_end;
  logic [3:0]              nibble;
  logic [6:0]              glyph_hi;
  logic [NUM_DIGITS-1:0]   lz_dark;
  logic                    digit_dark;
  logic [6:0]              seg_d;
  logic [NUM_DIGITS-1:0]   an_d;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  // slot_tick is decoded straight from the counter so it lines up with the
  // cycle in which digit_idx advances.
  assign slot_end  = (div_cnt == CNT_W'(REFRESH_DIV - 1));
  assign slot_tick = slot_end;

  assign nibble   = shadow[{digit_idx, 2'b00} +: 4];
  assign glyph_hi = glyph(nibble);

`ifdef SEG7_LZ_SUPPRESS_EN
  // Walk from the most significant digit down; a digit is dark while every
  // nibble from it upward is zero. Digit 0 is never suppressed.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_dark    = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (shadow[4*i +: 4] == 4'h0);
      lz_dark[i] = zero_above;
    end
  end
`else
  assign lz_dark = '0;
`endif

  assign digit_dark = blank_mask[digit_idx] | lz_dark[digit_idx];

  // Anodes stay off for the first cycle of every slot so the segment lines
  // can settle on the new glyph before any digit is lit.
  always_comb begin
    seg_d = SEG_OFF;
    an_d  = '1;
    if (!digit_dark) begin
      seg_d = (SEG_ACT_LOW != 0) ? ~glyph_hi : glyph_hi;
      if (div_cnt != '0) begin
        an_d[digit_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow    <= '0;
      div_cnt   <= '0;
      digit_idx <= '0;
      seg       <= SEG_OFF;
      an        <= '1;
    end else begin
      if (load) begin
        shadow <= value;
      end
      if (slot_end) begin
        div_cnt <= '0;
        if (digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
          digit_idx <= '0;
        end else begin
          digit_idx <= digit_idx + IDX_W'(1);
        end
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
      seg <= seg_d;
      an  <= an_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h0;
  logic        load = 1'b0;
  logic [3:0]  blank_mask = 4'h0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        slot_tick;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .SEG_ACT_LOW(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .load      (load),
    .blank_mask(blank_mask),
    .seg       (seg),
    .an        (an),
    .digit_idx (digit_idx),
    .slot_tick (slot_tick)
  );

  typedef struct {
    int         tag;
    logic [1:0] idx;
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic logic [6:0] glyph_hi(input logic [3:0] n);
    logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  task automatic push_hand(input int tag, input int idx, input logic [3:0] a, input logic [6:0] s);
    exp_t e;
    e.tag = tag; e.idx = 2'(idx); e.an = a; e.seg = s;
    sb.push_back(e);
  endtask

  task automatic push_slot(input int tag, input int idx, input logic [15:0] sh, input logic [3:0] bm);
    logic       dark;
    logic [3:0] onehot;
    exp_t       e;
    dark = bm[idx];
`ifdef SEG7_LZ_SUPPRESS_EN
    if (idx > 0 && (sh >> (4 * idx)) == 16'h0) dark = 1'b1;
`endif
    onehot = 4'b0001 << idx;
    e.tag = tag;
    e.idx = 2'(idx);
    e.an  = dark ? 4'hF : ~onehot;
    e.seg = dark ? 7'h7F : ~glyph_hi(sh[4*idx +: 4]);
    sb.push_back(e);
  endtask

  task automatic push_frame(input int tag, input logic [15:0] sh, input logic [3:0] bm);
    for (int i = 0; i < ND; i++) push_slot(tag, i, sh, bm);
  endtask

  // Monitor: checks reset values, the settle-cycle anode blanking, the one-hot
  // anode rule and tick spacing, and pops the scoreboard on every slot_tick.
  initial begin
    logic rst_prev;
    logic rst_seen;
    int   cyc;
    int   since_tick;
    int   last_tick;
    exp_t e;
    rst_prev   = 1'b0;
    cyc        = 0;
    since_tick = -1;
    last_tick  = -1;
    forever begin
      @(negedge clk);
      cyc++;
      rst_seen = rst_prev;
      rst_prev = reset;
      if (rst_seen) begin
        check("reset_an", 32'(an), 32'hF);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_idx", 32'(digit_idx), 32'h0);
        check("reset_tick", 32'(slot_tick), 32'h0);
        since_tick = -1;
        last_tick  = -1;
      end else begin
        check("an_onehot", 32'($countones(~an) <= 1), 32'h1);
        if (since_tick >= 0) since_tick++;
        if (since_tick == 2) check("guard_an", 32'(an), 32'hF);
        if (slot_tick) begin
          if (last_tick >= 0) check("tick_period", 32'(cyc - last_tick), 32'(RD));
          last_tick  = cyc;
          since_tick = 0;
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL slot_unexpected: tick at idx %0d with no expected slot", digit_idx);
          end else begin
            e = sb.pop_front();
            check($sformatf("t%0d_idx", e.tag), 32'(digit_idx), 32'(e.idx));
            check($sformatf("t%0d_an_d%0d", e.tag, e.idx), 32'(an), 32'(e.an));
            check($sformatf("t%0d_seg_d%0d", e.tag, e.idx), 32'(seg), 32'(e.seg));
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns in the first cycle of the slot following the last expected one.
  task automatic drain(input string name);
    int g;
    g = 0;
    while (sb.size() != 0 && g < 300) begin
      step(1);
      g++;
    end
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL %s_timeout: %0d slots pending required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    reset = 1'b1;
    step(3);

    // Load 12AF right out of reset; hand-computed active-low glyphs.
    reset = 1'b0;
    load  = 1'b1;
    value = 16'h12AF;
    push_hand(2, 0, 4'hE, 7'h0E);
    push_hand(2, 1, 4'hD, 7'h08);
    push_hand(2, 2, 4'hB, 7'h24);
    push_hand(2, 3, 4'h7, 7'h79);
    step(1);
    load = 1'b0;
    drain("t2");

    // Free run three frames.
    for (int f = 0; f < 3; f++) push_frame(3, 16'h12AF, 4'h0);
    drain("t3");

    // Blank digit 2 with all eights.
    load       = 1'b1;
    value      = 16'h8888;
    blank_mask = 4'b0100;
    push_hand(4, 0, 4'hE, 7'h00);
    push_hand(4, 1, 4'hD, 7'h00);
    push_hand(4, 2, 4'hF, 7'h7F);
    push_hand(4, 3, 4'h7, 7'h00);
    step(1);
    load = 1'b0;
    drain("t4");
    blank_mask = 4'h0;

    // Reset held three cycles mid-slot; shadow clears, scan restarts at 0.
    step(1);
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    push_frame(1, 16'h0000, 4'h0);
    drain("t1");

    // Load coinciding with a slot wrap.
    load  = 1'b1;
    value = 16'h12AF;
    step(1);
    load = 1'b0;
    push_slot(5, 0, 16'h12AF, 4'h0);
    push_slot(5, 1, 16'h00F0, 4'h0);
    push_slot(5, 2, 16'h00F0, 4'h0);
    push_slot(5, 3, 16'h00F0, 4'h0);
    push_frame(5, 16'h00F0, 4'h0);
    g = 0;
    while (!slot_tick && g < 20) begin
      step(1);
      g++;
    end
    if (!slot_tick) begin
      checks++;
      $display("FAIL t5_wait: slot_tick got 0 required 1");
    end
    load  = 1'b1;
    value = 16'h00F0;
    step(1);
    load = 1'b0;
    drain("t5");

    // Leading zeros (dark only with suppression built in).
    load  = 1'b1;
    value = 16'h0030;
    push_frame(6, 16'h0030, 4'h0);
    step(1);
    load = 1'b0;
    drain("t6a");
    load  = 1'b1;
    value = 16'h0000;
    push_frame(7, 16'h0000, 4'h0);
    step(1);
    load = 1'b0;
    drain("t6b");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
